lcd_bus_arbiter: RTL and testbench

Shares one HD44780-style character-LCD bus between two independent requesters, for example a keypad entry writer and a status/clock writer. After reset it runs the power-on initialisation sequence on its own. It then grants whole command or data transactions round-robin, driving RS/RW/DATA and an explicit E strobe with per-command hold times. It sits between the LCD pins and the application-level text/cursor logic.

---
 rtl/lcd_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_arbiter.sv
// ============================================================================
//  Module   : lcd_bus_arbiter
//  Purpose  : Shares one HD44780-style character-LCD bus between two
//             requesters. Runs the power-on init sequence, then grants whole
//             command/data transactions round-robin. It drives RS/RW/DATA
//             and an explicit E strobe, with per-command hold times.
//  Options  : LCD_ARB_PRIORITY_EN - when defined, requester 0 always wins
//             simultaneous requests (fixed priority, no round-robin pointer).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_bus_arbiter #(
  parameter int INIT_WAIT = 70,
  parameter int CMD_HOLD  = 30,
  parameter int CLR_HOLD  = 100,
  parameter int E_WIDTH   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       rs_i0,
  input  logic [7:0] data_i0,
  input  logic       rs_i1,
  input  logic [7:0] data_i1,
  output logic [1:0] ack,
  output logic       busy,
  output logic       init_done,
  output logic       E,
  output logic       RS,
  output logic       RW,
  output logic [7:0] DATA
);

  // Counter is 8 bits wide, so every hold length fits in 8 bits.
  localparam logic [7:0] c_init_wait = 8'(INIT_WAIT);
  localparam logic [7:0] c_cmd_hold  = 8'(CMD_HOLD);
  localparam logic [7:0] c_clr_hold  = 8'(CLR_HOLD);
  localparam logic [7:0] c_e_width   = 8'(E_WIDTH);

  typedef enum logic [2:0] {
    W_PWR   = 3'd0,
    I_FUNC  = 3'd1,
    I_DISP  = 3'd2,
    I_ENTRY = 3'd3,
    I_CLR   = 3'd4,
    IDLE    = 3'd5,
    XFER    = 3'd6
  } state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [7:0] w_hold;
  logic       w_end;
  logic       w_is_clr;
  logic       w_win;

`ifndef LCD_ARB_PRIORITY_EN
  logic       r_last;
`endif

  // Clear/home commands need the long hold; RS/DATA are the latched transaction.
  assign w_is_clr = ~RS && (DATA == 8'h01 || DATA == 8'h02 || DATA == 8'h03);

  // Length of the timed phase the FSM is currently in.
  always_comb begin
    w_hold = c_cmd_hold;
    case (r_state)
      W_PWR:   w_hold = c_init_wait;
      I_CLR:   w_hold = c_clr_hold;
      XFER:    w_hold = w_is_clr ? c_clr_hold : c_cmd_hold;
      default: w_hold = c_cmd_hold;
    endcase
  end

  assign w_end = (r_cnt == w_hold - 8'd1);

  // Pick the winning requester; only meaningful when some req bit is set.
  always_comb begin
`ifdef LCD_ARB_PRIORITY_EN
    w_win = ~req[0];
`else
    if (req == 2'b11) w_win = ~r_last;
    else              w_win = req[1];
`endif
  end

  // Main FSM: init sequencing, arbitration and transaction timing, registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= W_PWR;
      r_cnt     <= 8'd0;
      E         <= 1'b0;
      RS        <= 1'b0;
      RW        <= 1'b0;
      DATA      <= 8'h00;
      ack       <= 2'b00;
      busy      <= 1'b1;
      init_done <= 1'b0;
`ifndef LCD_ARB_PRIORITY_EN
      r_last    <= 1'b1;
`endif
    end else begin
      ack <= 2'b00;
      RW  <= 1'b0;
      case (r_state)
        IDLE: begin
          E <= 1'b0;
          if (req != 2'b00) begin
            r_state <= XFER;
            r_cnt   <= 8'd0;
            busy    <= 1'b1;
            ack     <= w_win ? 2'b10 : 2'b01;
            RS      <= w_win ? rs_i1 : rs_i0;
            DATA    <= w_win ? data_i1 : data_i0;
`ifndef LCD_ARB_PRIORITY_EN
            r_last  <= w_win;
`endif
          end
        end
        default: begin
          if (w_end) begin
            // Phase complete: load the next init command or go back to IDLE.
            r_cnt <= 8'd0;
            E     <= 1'b0;
            case (r_state)
              W_PWR: begin
                r_state <= I_FUNC;
                RS      <= 1'b0;
                DATA    <= 8'h38;
              end
              I_FUNC: begin
                r_state <= I_DISP;
                RS      <= 1'b0;
                DATA    <= 8'h0C;
              end
              I_DISP: begin
                r_state <= I_ENTRY;
                RS      <= 1'b0;
                DATA    <= 8'h06;
              end
              I_ENTRY: begin
                r_state <= I_CLR;
                RS      <= 1'b0;
                DATA    <= 8'h01;
              end
              default: begin
                r_state   <= IDLE;
                busy      <= 1'b0;
                RS        <= 1'b0;
                DATA      <= 8'h00;
                init_done <= 1'b1;
              end
            endcase
          end else begin
            // E is high for cnt in [1, E_WIDTH]; set it one cycle early since it is registered.
            r_cnt <= r_cnt + 8'd1;
            E     <= (r_state != W_PWR) && (r_cnt < c_e_width);
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_arbiter.sv
// ============================================================================
//  Module   : tb_lcd_bus_arbiter
//  Purpose  : Self-checking bench for lcd_bus_arbiter. A transaction-schedule
//             reference model predicts every output, cycle by cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_bus_arbiter;

  localparam int INIT_WAIT = 70;
  localparam int CMD_HOLD  = 30;
  localparam int CLR_HOLD  = 100;
  localparam int E_WIDTH   = 8;
  localparam int INIT_END  = INIT_WAIT + 3 * CMD_HOLD + CLR_HOLD;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic       rs_i0, rs_i1;
  logic [7:0] data_i0, data_i1;
  logic [1:0] ack;
  logic       busy, init_done, E, RS, RW;
  logic [7:0] DATA;

  lcd_bus_arbiter #(
    .INIT_WAIT(INIT_WAIT), .CMD_HOLD(CMD_HOLD), .CLR_HOLD(CLR_HOLD), .E_WIDTH(E_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .rs_i0(rs_i0), .data_i0(data_i0), .rs_i1(rs_i1), .data_i1(data_i1),
    .ack(ack), .busy(busy), .init_done(init_done),
    .E(E), .RS(RS), .RW(RW), .DATA(DATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the current (or most recent) bus transaction.
  int         t;
  bit         cur_valid;
  int         cur_s, cur_hold;
  logic       cur_rs;
  logic [7:0] cur_data;
  bit         cur_xfer;
  int         cur_w;
  int         last;
  int         grants;

  // Requester-side bench state.
  logic [1:0] r_req;
  logic       r_rs[2];
  logic [7:0] r_data[2];

  // Observed acks (from the DUT) for ordering and spacing checks.
  int obs_w[$];
  int obs_t[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, expv);
    end
  endtask

  task automatic drive();
    req     = r_req;
    rs_i0   = r_rs[0];
    data_i0 = r_data[0];
    rs_i1   = r_rs[1];
    data_i1 = r_data[1];
  endtask

  function automatic int hold_of(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? CLR_HOLD : CMD_HOLD;
  endfunction

  task automatic new_byte(input int n, input bit allow_clr);
    r_req[n] = 1'b1;
    if (allow_clr && $urandom_range(3) == 0) begin
      r_rs[n]   = 1'b0;
      r_data[n] = 8'($urandom_range(3, 1));
    end else begin
      r_rs[n]   = 1'($urandom_range(1));
      r_data[n] = 8'($urandom);
      if (!allow_clr && !r_rs[n] && r_data[n] >= 8'h01 && r_data[n] <= 8'h03)
        r_data[n] = r_data[n] + 8'h10;
    end
  endtask

  task automatic set_init(input int s, input int h, input logic [7:0] d);
    cur_valid = 1; cur_s = s; cur_hold = h; cur_rs = 1'b0; cur_data = d; cur_xfer = 0;
  endtask

  // One cycle: check outputs against the schedule, update requesters, arbitrate, advance.
  task automatic step(input int pr_new, input int pr_drop, input bit allow_clr);
    bit         in_tx;
    int         off;
    logic [1:0] e_ack;
    int         w;
    if (t == INIT_WAIT)                  set_init(t, CMD_HOLD, 8'h38);
    if (t == INIT_WAIT + CMD_HOLD)       set_init(t, CMD_HOLD, 8'h0C);
    if (t == INIT_WAIT + 2 * CMD_HOLD)   set_init(t, CMD_HOLD, 8'h06);
    if (t == INIT_WAIT + 3 * CMD_HOLD)   set_init(t, CLR_HOLD, 8'h01);
    in_tx = cur_valid && t >= cur_s && t < cur_s + cur_hold;
    off   = t - cur_s;
    e_ack = (in_tx && cur_xfer && off == 0) ? (cur_w == 1 ? 2'b10 : 2'b01) : 2'b00;

    chk("E",         32'(E),         32'(in_tx && off >= 1 && off <= E_WIDTH));
    chk("RS",        32'(RS),        32'(in_tx ? cur_rs : 1'b0));
    chk("DATA",      32'(DATA),      32'(in_tx ? cur_data : 8'h00));
    chk("RW",        32'(RW),        32'(0));
    chk("busy",      32'(busy),      32'(t < INIT_END || in_tx));
    chk("init_done", 32'(init_done), 32'(t >= INIT_END));
    chk("ack",       32'(ack),       32'(e_ack));
    if (ack !== 2'b00) begin
      obs_w.push_back(ack[1] === 1'b1 ? 1 : 0);
      obs_t.push_back(t);
    end

    for (int n = 0; n < 2; n++) begin
      if (r_req[n] && e_ack[n]) begin
        if (int'($urandom_range(99)) < pr_new) new_byte(n, allow_clr);
        else r_req[n] = 1'b0;
      end else if (r_req[n]) begin
        if (int'($urandom_range(99)) < pr_drop) r_req[n] = 1'b0;
      end else if (int'($urandom_range(99)) < pr_new) begin
        new_byte(n, allow_clr);
      end
    end
    drive();

    if (t >= INIT_END && t >= cur_s + cur_hold && r_req != 2'b00) begin
`ifdef LCD_ARB_PRIORITY_EN
      w = r_req[0] ? 0 : 1;
`else
      if (r_req == 2'b11) w = 1 - last;
      else                w = r_req[1] ? 1 : 0;
`endif
      cur_valid = 1; cur_s = t + 1; cur_rs = r_rs[w]; cur_data = r_data[w];
      cur_hold  = hold_of(r_rs[w], r_data[w]); cur_xfer = 1; cur_w = w;
      last      = w;
      grants++;
    end

    @(negedge clk);
    t++;
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    r_req = 2'b00;
    drive();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    t = 0; cur_valid = 0; cur_s = 0; cur_hold = 0; cur_xfer = 0; cur_w = 0; last = 1;
  endtask

  // Run until the bus is idle with nothing pending, then one extra idle cycle.
  task automatic drain();
    int k;
    k = 0;
    while (!(t >= INIT_END && t >= cur_s + cur_hold && r_req == 2'b00) && k < 600) begin
      step(0, 0, 0);
      k++;
    end
    step(0, 0, 0);
  endtask

  initial begin
    int g0, k;
    int exp_order[4];
    r_rs[0] = 0; r_rs[1] = 0; r_data[0] = 0; r_data[1] = 0;
    grants = 0;
    t = 0;
    do_reset();

    // Init sequence, with requester 1 asking from cycle 5 onward.
    while (t < 5) step(0, 0, 0);
    r_req[1] = 1'b1; r_rs[1] = 1'b1; r_data[1] = 8'h4B;
    drive();
    while (t < INIT_END + 5) step(0, 0, 0);
    chk("init_ack_count", 32'(obs_w.size()), 32'(1));
    if (obs_w.size() >= 1) begin
      chk("init_ack_who",  32'(obs_w[0]), 32'(1));
      chk("init_ack_time", 32'(obs_t[0]), 32'(INIT_END + 1));
    end
    drain();

    // Simultaneous requests held across four grants.
    obs_w.delete(); obs_t.delete();
    new_byte(0, 0); new_byte(1, 0); drive();
    g0 = grants; k = 0;
    while (grants - g0 < 4 && k < 400) begin step(100, 0, 0); k++; end
    drain();
`ifdef LCD_ARB_PRIORITY_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    chk("sim_ack_count", 32'(obs_w.size() >= 4), 32'(1));
    if (obs_w.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("sim_order", 32'(obs_w[i]), 32'(exp_order[i]));
      for (int i = 0; i < 3; i++) chk("sim_spacing", 32'(obs_t[i+1] - obs_t[i]), 32'(CMD_HOLD + 1));
    end

    // Single data write from requester 0.
    obs_w.delete(); obs_t.delete();
    r_req[0] = 1'b1; r_rs[0] = 1'b1; r_data[0] = 8'h31; drive();
    drain();
    chk("single_count", 32'(obs_w.size()), 32'(1));
    if (obs_w.size() >= 1) chk("single_who", 32'(obs_w[0]), 32'(0));

    // Clear display from requester 1 followed by a data byte from requester 0.
    obs_w.delete(); obs_t.delete();
    r_req[1] = 1'b1; r_rs[1] = 1'b0; r_data[1] = 8'h01; drive();
    g0 = grants; k = 0;
    while (grants == g0 && k < 100) begin step(0, 0, 0); k++; end
    r_req[0] = 1'b1; r_rs[0] = 1'b1; r_data[0] = 8'h48; drive();
    drain();
    chk("long_count", 32'(obs_w.size()), 32'(2));
    if (obs_w.size() == 2) begin
      chk("long_first",  32'(obs_w[0]), 32'(1));
      chk("long_second", 32'(obs_w[1]), 32'(0));
      chk("long_gap",    32'(obs_t[1] - obs_t[0]), 32'(CLR_HOLD + 1));
    end

    // Random traffic with withdrawals and clear commands.
    for (int i = 0; i < 1500; i++) step(30, 5, 1);
    drain();

    // Reset at cnt=10 of a data transaction, then a full init replay.
    r_req[0] = 1'b1; r_rs[0] = 1'b1; r_data[0] = 8'($urandom); drive();
    k = 0;
    while (!(cur_xfer && t == cur_s + 10) && k < 100) begin step(0, 0, 0); k++; end
    r_req = 2'b00; drive();
    rst = 1'b0;
    #1;
    chk("rst_E",         32'(E),         32'(0));
    chk("rst_DATA",      32'(DATA),      32'(0));
    chk("rst_RS",        32'(RS),        32'(0));
    chk("rst_init_done", 32'(init_done), 32'(0));
    chk("rst_ack",       32'(ack),       32'(0));
    chk("rst_busy",      32'(busy),      32'(1));
    do_reset();
    obs_w.delete(); obs_t.delete();
    while (t < INIT_END + 10) step(0, 0, 0);
    chk("replay_no_ack", 32'(obs_w.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
